// File: rtl/slc3_io_bridge.sv
// slc3_io_bridge: SLC-3 board I/O (button sync/debounce, switch/hex MMIO, PAUSE handshake).
// Define IO_DEBOUNCE_EN for counter debounce; otherwise buttons use a falling-edge detect.
module slc3_io_bridge #(
  parameter logic [15:0] IO_ADDR         = 16'hFFFF,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run_n,
  input  logic        Continue_n,
  input  logic [9:0]  SW,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR_wr,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic        pause_req,
  input  logic [9:0]  pause_led,
  output logic        io_hit,
  output logic [15:0] io_rdata,
  output logic        run_pulse,
  output logic        pause_ack,
  output logic [9:0]  LED,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, PAUSED, RELEASE} state_t;

  state_t      state, state_n;
  logic [1:0]  btn_s1, btn_s2, btn_pulse;
  logic [9:0]  sw_s1, sw_s2;
  logic [9:0]  led_q;
  logic        led_load;
  logic        cont_pulse;
  logic [15:0] hex_reg;

  // bit 0 = Run, bit 1 = Continue; released level is 1
  always_ff @(posedge Clk) begin
    if (Reset) begin
      btn_s1 <= 2'b11;
      btn_s2 <= 2'b11;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= {Continue_n, Run_n};
      btn_s2 <= btn_s1;
      sw_s1  <= SW;
      sw_s2  <= sw_s1;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt [2];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt[0]    <= '0;
      cnt[1]    <= '0;
      btn_pulse <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        btn_pulse[i] <= 1'b0;
        if (btn_s2[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != CNT_MAX) begin
          cnt[i]       <= cnt[i] + CNT_ONE;
          btn_pulse[i] <= (cnt[i] + CNT_ONE == CNT_MAX);
        end
      end
    end
  end
`else
  logic [1:0] btn_prev;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      btn_prev  <= 2'b11;
      btn_pulse <= '0;
    end else begin
      btn_prev  <= btn_s2;
      btn_pulse <= btn_prev & ~btn_s2;
    end
  end
`endif

  assign run_pulse  = btn_pulse[0];
  assign cont_pulse = btn_pulse[1];
  assign io_hit     = (MAR == IO_ADDR);

  // a simultaneous read and write is treated as a write only
  always_ff @(posedge Clk) begin
    if (Reset) begin
      io_rdata <= '0;
      hex_reg  <= '0;
    end else if (io_hit && Mem_WE) begin
      hex_reg  <= MDR_wr;
    end else if (io_hit && Mem_OE) begin
      io_rdata <= {6'b0, sw_s2};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      led_q <= '0;
    end else begin
      state <= state_n;
      if (led_load) led_q <= pause_led;
    end
  end

  always_comb begin
    state_n   = state;
    led_load  = 1'b0;
    pause_ack = 1'b0;
    LED       = led_q;
    unique case (state)
      IDLE: begin
        LED = '0;
        if (pause_req) begin
          state_n  = PAUSED;
          led_load = 1'b1;
        end
      end
      PAUSED: begin
        if (cont_pulse && !Reset) begin
          pause_ack = 1'b1;
          state_n   = RELEASE;
        end
      end
      RELEASE: begin
        if (!pause_req) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign HEX0 = seg7(hex_reg[3:0]);
  assign HEX1 = seg7(hex_reg[7:4]);
  assign HEX2 = seg7(hex_reg[11:8]);
  assign HEX3 = seg7(hex_reg[15:12]);

endmodule

// File: tb/tb_slc3_io_bridge.sv
// tb_slc3_io_bridge: vector table, directed handshake sequences and random traffic
// checked against a cycle-history model of slc3_io_bridge.
module tb_slc3_io_bridge;
`ifdef IO_DEBOUNCE_EN
  localparam int N = 16;
`else
  localparam int N = 1;
`endif
  localparam int LAT = N + 2;
  localparam int NC  = 8192;

  logic        Clk = 1'b0;
  logic        Reset, Run_n, Continue_n;
  logic [9:0]  SW, pause_led;
  logic [15:0] MAR, MDR_wr;
  logic        Mem_OE, Mem_WE, pause_req;
  logic        io_hit, run_pulse, pause_ack;
  logic [15:0] io_rdata;
  logic [9:0]  LED;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;

  always #5 Clk = ~Clk;

  slc3_io_bridge #(.IO_ADDR(16'hFFFF), .DEBOUNCE_CYCLES(16)) dut (
    .Clk(Clk), .Reset(Reset), .Run_n(Run_n), .Continue_n(Continue_n),
    .SW(SW), .MAR(MAR), .MDR_wr(MDR_wr), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .pause_req(pause_req), .pause_led(pause_led), .io_hit(io_hit),
    .io_rdata(io_rdata), .run_pulse(run_pulse), .pause_ack(pause_ack),
    .LED(LED), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  typedef struct {
    logic [15:0] mar;
    logic        oe;
    logic        we;
    logic [15:0] wd;
    logic        hit;
    logic [15:0] rd;
    logic [27:0] hex;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // raw pin history per cycle; slots overwritten by what the synchronisers see after reset
  bit          hr [NC];
  bit          hc [NC];
  logic [9:0]  hsw [NC];
  int          cyc;
  bit          rst_prev;
  int          m_mode;
  logic [9:0]  m_led;
  logic [15:0] m_hex, m_rd;
  logic [6:0]  seg_tab [16];
  int          n_run, n_ack, last_run;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit lvl(input int b, input int j);
    return (b == 0) ? hr[j] : hc[j];
  endfunction

  // pulse in cycle k: raw low for exactly the last N sampled cycles ending k-3
  function automatic bit pulse_at(input int b, input int k);
    if (rst_prev) return 1'b0;
    for (int j = k - 2 - N; j <= k - 3; j++)
      if (lvl(b, j)) return 1'b0;
    return lvl(b, k - 3 - N);
  endfunction

  function automatic logic [27:0] seg4(input logic [15:0] v);
    return {seg_tab[v[15:12]], seg_tab[v[11:8]], seg_tab[v[7:4]], seg_tab[v[3:0]]};
  endfunction

  task automatic step();
    bit er, ec, ea;
    logic [9:0] eled;
    @(negedge Clk);
    er   = pulse_at(0, cyc);
    ec   = pulse_at(1, cyc);
    ea   = (m_mode == 1) && ec && !Reset;
    eled = (m_mode == 0) ? 10'd0 : m_led;
    chk("run_pulse", run_pulse, er);
    chk("pause_ack", pause_ack, ea);
    chk("led", LED, eled);
    chk("io_hit", io_hit, MAR == 16'hFFFF);
    chk("io_rdata", io_rdata, m_rd);
    chk("hex", {HEX3, HEX2, HEX1, HEX0}, seg4(m_hex));
    if (run_pulse === 1'b1) begin
      n_run++;
      last_run = cyc;
    end
    if (pause_ack === 1'b1) n_ack++;
    @(posedge Clk);
    hr[cyc]  = Run_n;
    hc[cyc]  = Continue_n;
    hsw[cyc] = SW;
    if (Reset) begin
      hr[cyc-1] = 1'b1;  hr[cyc] = 1'b1;
      hc[cyc-1] = 1'b1;  hc[cyc] = 1'b1;
      hsw[cyc-1] = '0;   hsw[cyc] = '0;
      m_mode = 0; m_led = '0; m_hex = '0; m_rd = '0;
    end else begin
      if (MAR == 16'hFFFF && Mem_WE) m_hex = MDR_wr;
      else if (MAR == 16'hFFFF && Mem_OE) m_rd = {6'd0, hsw[cyc-2]};
      case (m_mode)
        0: if (pause_req) begin
          m_mode = 1;
          m_led  = pause_led;
        end
        1: if (ec) m_mode = 2;
        default: if (!pause_req) m_mode = 0;
      endcase
    end
    rst_prev = Reset;
    cyc++;
    if (cyc >= NC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, NC);
      $fatal(1, "cycle budget exhausted");
    end
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [8];
    int   p, run_left, cont_left;

    for (int i = 0; i < NC; i++) begin
      hr[i] = 1'b1; hc[i] = 1'b1; hsw[i] = '0;
    end
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vt[0] = '{16'h3000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, {7'h40, 7'h40, 7'h40, 7'h40}};
    vt[1] = '{16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0014, {7'h40, 7'h40, 7'h40, 7'h40}};
    vt[2] = '{16'h3000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0014, {7'h40, 7'h40, 7'h40, 7'h40}};
    vt[3] = '{16'hFFFF, 1'b0, 1'b1, 16'h1234, 1'b1, 16'h0014, {7'h79, 7'h24, 7'h30, 7'h19}};
    vt[4] = '{16'h0000, 1'b0, 1'b1, 16'hABCD, 1'b0, 16'h0014, {7'h79, 7'h24, 7'h30, 7'h19}};
    vt[5] = '{16'hFFFF, 1'b1, 1'b1, 16'h5678, 1'b1, 16'h0014, {7'h12, 7'h02, 7'h78, 7'h00}};
    vt[6] = '{16'hFFFF, 1'b0, 1'b1, 16'h9ABC, 1'b1, 16'h0014, {7'h10, 7'h08, 7'h03, 7'h46}};
    vt[7] = '{16'hFFFF, 1'b0, 1'b1, 16'hDEF0, 1'b1, 16'h0014, {7'h21, 7'h06, 7'h0E, 7'h40}};

    Reset = 1'b1; Run_n = 1'b1; Continue_n = 1'b1; SW = '0;
    MAR = '0; MDR_wr = '0; Mem_OE = 1'b0; Mem_WE = 1'b0;
    pause_req = 1'b0; pause_led = '0;
    cyc = 32; rst_prev = 1'b1; m_mode = 0; m_led = '0; m_hex = '0; m_rd = '0;
    n_run = 0; n_ack = 0; last_run = 0;

    repeat (2) @(posedge Clk);
    #1;
    step();
    chk("rst_led", LED, 10'h000);
    chk("rst_hex", {HEX3, HEX2, HEX1, HEX0}, {7'h40, 7'h40, 7'h40, 7'h40});
    chk("rst_run", run_pulse, 1'b0);
    chk("rst_ack", pause_ack, 1'b0);
    Reset = 1'b0;
    repeat (3) step();

    n_run = 0; p = cyc; Run_n = 1'b0;
    repeat (20) step();
    Run_n = 1'b1;
    repeat (25) step();
    chk("run_count", n_run, 1);
    chk("run_latency", last_run - p, LAT);
`ifdef IO_DEBOUNCE_EN
    n_run = 0; Run_n = 1'b0;
    repeat (10) step();
    Run_n = 1'b1;
    repeat (25) step();
    chk("run_short", n_run, 0);
    Run_n = 1'b0;
    repeat (12) step();
    Run_n = 1'b1;
    step();
    Run_n = 1'b0;
    repeat (12) step();
    Run_n = 1'b1;
    repeat (25) step();
    chk("run_bounce", n_run, 0);
`endif

    SW = 10'h014;
    repeat (3) step();
    for (int i = 0; i < 8; i++) begin
      MAR = vt[i].mar; Mem_OE = vt[i].oe; Mem_WE = vt[i].we; MDR_wr = vt[i].wd;
      #1;
      chk("vec_hit", io_hit, vt[i].hit);
      step();
      chk("vec_rdata", io_rdata, vt[i].rd);
      chk("vec_hex", {HEX3, HEX2, HEX1, HEX0}, vt[i].hex);
    end
    Mem_OE = 1'b0; Mem_WE = 1'b0;

    pause_led = 10'h00A; pause_req = 1'b1;
    repeat (2) step();
    chk("pause_led", LED, 10'h00A);
    pause_led = 10'h3FF;
    step();
    chk("pause_led_hold", LED, 10'h00A);
    n_ack = 0; Continue_n = 1'b0;
    repeat (20) step();
    Continue_n = 1'b1;
    repeat (5) step();
    chk("ack_once", n_ack, 1);
    n_ack = 0;
    repeat (5) step();
    Continue_n = 1'b0;
    repeat (20) step();
    Continue_n = 1'b1;
    repeat (5) step();
    chk("ack_no_double", n_ack, 0);
    pause_req = 1'b0;
    repeat (2) step();
    chk("led_idle", LED, 10'h000);

    n_ack = 0; Continue_n = 1'b0;
    repeat (LAT) step();
    pause_req = 1'b1; pause_led = 10'h155;
    repeat (11) step();
    chk("same_cycle_led", LED, 10'h155);
    chk("same_cycle_no_ack", n_ack, 0);
    Continue_n = 1'b1;
    repeat (3) step();
    Continue_n = 1'b0;
    repeat (20) step();
    Continue_n = 1'b1; pause_req = 1'b0;
    repeat (5) step();
    chk("same_cycle_later_ack", n_ack, 1);

    pause_led = 10'h2C3; pause_req = 1'b1;
    repeat (2) step();
    chk("rst_pause_led_on", LED, 10'h2C3);
    n_ack = 0; Continue_n = 1'b0;
    step();
    Reset = 1'b1; pause_req = 1'b0;
    step();
    Reset = 1'b0;
    repeat (30) step();
    Continue_n = 1'b1;
    repeat (5) step();
    chk("rst_pause_led", LED, 10'h000);
    chk("rst_pause_no_ack", n_ack, 0);

    run_left = 0; cont_left = 0;
    for (int it = 0; it < 1500; it++) begin
      if (run_left == 0) begin
        Run_n = ~Run_n;
        run_left = $urandom_range(1, 24);
      end
      if (cont_left == 0) begin
        Continue_n = ~Continue_n;
        cont_left = $urandom_range(1, 24);
      end
      run_left--; cont_left--;
      if ($urandom_range(0, 29) == 0) pause_req = ~pause_req;
      MAR    = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom());
      Mem_OE = ($urandom_range(0, 3) == 0);
      Mem_WE = ($urandom_range(0, 3) == 0);
      MDR_wr = 16'($urandom());
      if ($urandom_range(0, 7) == 0) SW = 10'($urandom());
      pause_led = 10'($urandom());
      Reset = ($urandom_range(0, 249) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
